pipelined_block_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/block_adder.sv | 25 ++
 rtl/pipelined_block_adder.sv | 141 ++++++++++++++
 tb/tb_pipelined_block_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and geometry helpers for the pipelined block adder family
package adder_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_BLOCK = 16;

  function automatic int calc_stages(input int width, input int block);
    return (block > 0) ? width / block : 0;
  endfunction

  // A usable geometry has at least one stage and no partial block.
  function automatic bit width_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/block_adder.sv
// rtl/block_adder.sv - BLOCK-bit combinational ripple-carry adder used by each pipeline stage
module block_adder
  import adder_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);

  logic [BLOCK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    assign s[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[BLOCK];

endmodule

// File: rtl/pipelined_block_adder.sv
// rtl/pipelined_block_adder.sv - WIDTH-bit adder split into BLOCK-bit carry-chained pipeline stages
// Optional signed-overflow output and sign forwarding enabled by defining ADDER_OVF_EN.
module pipelined_block_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int STAGES = calc_stages(WIDTH, BLOCK);
  localparam int LAST   = STAGES - 1;

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_block_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // One global enable: a stalled output freezes every stage at once.
  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Each g_stage[k] holds the inputs seen by stage k; for k>0 they are registers
  // loaded from stage k-1, so stage k's adder sits between two register levels.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [WIDTH-1:0] s_nxt;
    logic [BLOCK-1:0] s_blk;
    logic             c_blk;
`ifdef ADDER_OVF_EN
    logic             sa_i;
    logic             sb_i;
`endif

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = b;
      assign s_i = '0;
      assign c_i = c0;
      assign v_i = in_valid;
`ifdef ADDER_OVF_EN
      assign sa_i = a[WIDTH-1];
      assign sb_i = b[WIDTH-1];
`endif
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          a_i <= '0;
          b_i <= '0;
          s_i <= '0;
          c_i <= 1'b0;
          v_i <= 1'b0;
`ifdef ADDER_OVF_EN
          sa_i <= 1'b0;
          sb_i <= 1'b0;
`endif
        end else if (adv) begin
          a_i <= g_stage[k-1].a_i;
          b_i <= g_stage[k-1].b_i;
          s_i <= g_stage[k-1].s_nxt;
          c_i <= g_stage[k-1].c_blk;
          v_i <= g_stage[k-1].v_i;
`ifdef ADDER_OVF_EN
          sa_i <= g_stage[k-1].sa_i;
          sb_i <= g_stage[k-1].sb_i;
`endif
        end
      end
    end

    block_adder #(
      .BLOCK(BLOCK)
    ) u_block_adder (
      .x    (a_i[k*BLOCK +: BLOCK]),
      .y    (b_i[k*BLOCK +: BLOCK]),
      .cin  (c_i),
      .s    (s_blk),
      .cout (c_blk)
    );

    // Lower blocks already finished ride along; this stage fills in its own slice.
    always_comb begin
      s_nxt                    = s_i;
      s_nxt[k*BLOCK +: BLOCK]  = s_blk;
    end
  end

`ifdef ADDER_OVF_EN
  logic sa_q;
  logic sb_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
`ifdef ADDER_OVF_EN
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= g_stage[LAST].v_i;
      sum       <= g_stage[LAST].s_nxt;
      c_out     <= g_stage[LAST].c_blk;
`ifdef ADDER_OVF_EN
      sa_q      <= g_stage[LAST].sa_i;
      sb_q      <= g_stage[LAST].sb_i;
`endif
    end
  end

`ifdef ADDER_OVF_EN
  // Overflow: like-signed operands producing a result of the opposite sign.
  assign ovf = (sa_q == sb_q) & (sum[WIDTH-1] != sa_q);
`endif

endmodule

// File: tb/tb_pipelined_block_adder.sv
// tb/tb_pipelined_block_adder.sv - self-checking bench for pipelined_block_adder (ADDER_OVF_EN aware)
module tb_pipelined_block_adder;

  localparam int W   = 64;
  localparam int STG = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic [W-1:0] e_sum;
    logic         e_c;
    logic         e_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef ADDER_OVF_EN
  logic         ovf;
  logic         s_ovf;
`endif

  logic         s_in_valid;
  logic         s_in_ready;
  logic [15:0]  s_a;
  logic [15:0]  s_b;
  logic         s_c0;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [15:0]  s_sum;
  logic         s_c_out;

  pipelined_block_adder #(.WIDTH(W), .BLOCK(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c0(c0), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ADDER_OVF_EN
    .sum(sum), .c_out(c_out), .ovf(ovf)
`else
    .sum(sum), .c_out(c_out)
`endif
  );

  pipelined_block_adder #(.WIDTH(16), .BLOCK(8)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .c0(s_c0), .out_valid(s_out_valid), .out_ready(s_out_ready),
`ifdef ADDER_OVF_EN
    .sum(s_sum), .c_out(s_c_out), .ovf(s_ovf)
`else
    .sum(s_sum), .c_out(s_c_out)
`endif
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_chk  = 1'b1;
  exp_t sb_q[$];
  int   pop_cyc[$];

  logic [W-1:0] drv_sum;
  logic         drv_c;
  logic         drv_ovf;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sum", sum, e.sum);
          check("c_out", c_out, e.c);
`ifdef ADDER_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
          if (lat_chk) check("latency", cyc - e.cyc, STG);
        end
        pop_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) sb_q.push_back('{drv_sum, drv_c, drv_ovf, cyc});
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                      input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    in_valid = 1'b1;
    a = va; b = vb; c0 = vc;
    drv_sum = es; drv_c = ec; drv_ovf = eo;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] full;
    full = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
    es = full[W-1:0];
    ec = full[W];
    eo = (va[W-1] == vb[W-1]) && (es[W-1] != va[W-1]);
  endtask

  task automatic send_model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    model(va, vb, vc, es, ec, eo);
    send(va, vb, vc, es, ec, eo);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    logic [W-1:0] ra, rb, es1;
    logic         rc, ec1, eo1;
    int           base, n;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[8] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 64'h0001_0000_0001_0001, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c0 = 1'b0;
    drv_sum = '0; drv_c = 1'b0; drv_ovf = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_c0 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
`ifdef ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < 9; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].e_sum, vecs[i].e_c, vecs[i].e_ovf);
    drain();

    // Random stream: ordering, full throughput.
    base = pop_cyc.size();
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      send_model(ra, rb, rc);
    end
    drain();
    check("stream_count", pop_cyc.size() - base, 100);
    if (pop_cyc.size() - base == 100)
      check("stream_span", pop_cyc[base + 99] - pop_cyc[base], 99);

    // Backpressure with full pipeline.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, es1, ec1, eo1);
    send_model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    send_model(64'h1, 64'h2, 1'b0);
    send_model(64'h3, 64'h4, 1'b1);
    send_model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0);
    in_valid = 1'b1;
    a = 64'h5; b = 64'h6; c0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, es1);
      check("stall_c_out", c_out, ec1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_model(64'h5, 64'h6, 1'b0);
    drain();
    lat_chk = 1'b1;

    // Reset with three transactions in flight.
    send_model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    send_model(64'h10, 64'h20, 1'b0);
    send_model(64'h30, 64'h40, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_out", out_valid, 0);
    end

    // Narrow instance: two stages, carry across the 8-bit boundary.
    @(posedge clk);
    #1;
    s_in_valid = 1'b1; s_a = 16'h00FF; s_b = 16'h0001; s_c0 = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_out_valid && n < 10);
    check("small_latency", n, 2);
    check("small_sum", s_sum, 16'h0101);
    check("small_c_out", s_c_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
